// File: rtl/led_playback_sequencer_if.sv
// Bundle between the LED playback sequencer and whatever drives it.
// The driving side also supplies the sequence memory read data.
interface led_playback_sequencer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 2
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH:0]   length;
  logic                  speed;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  led_red;
  logic                  led_green;
  logic                  led_blue;
  logic                  led_yellow;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, length, speed, mem_data,
    input  mem_rd, mem_addr, led_red, led_green, led_blue, led_yellow, busy, done
  );

  modport slave (
    input  start, abort, length, speed, mem_data,
    output mem_rd, mem_addr, led_red, led_green, led_blue, led_yellow, busy, done
  );
endinterface

// File: rtl/led_playback_sequencer.sv
// Plays a stored color sequence on four LEDs: fetch, latch, light for the
// captured on-time, then a dark gap, repeated for each item.
module led_playback_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 2,
  parameter int SLOW_ON    = 50_000_000,
  parameter int FAST_ON    = 12_500_000,
  parameter int GAP        = 5_000_000
) (
  input logic                    clk,
  input logic                    rst,
  led_playback_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_ON     = 3'd3;
  localparam logic [2:0] S_OFF    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam int MAX_ON  = (SLOW_ON > FAST_ON) ? SLOW_ON : FAST_ON;
  localparam int MAX_CNT = (MAX_ON > GAP) ? MAX_ON : GAP;
  localparam int TW      = $clog2(MAX_CNT + 1);
  localparam int IW      = ADDR_WIDTH + 1;

  localparam logic [TW-1:0] SLOW_LAST = TW'(SLOW_ON - 1);
  localparam logic [TW-1:0] FAST_LAST = TW'(FAST_ON - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP - 1);
  localparam logic [IW-1:0] MAX_LEN   = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [2:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         len_q, len_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [TW-1:0]         on_last_q, on_last_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;
  logic [IW-1:0]         idx_inc;

  assign idx_inc = idx_q + IW'(1);

  // Timers count 0..limit-1, so the stored limits are pre-decremented.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    timer_d   = timer_q;
    on_last_d = on_last_q;
    color_d   = color_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          len_d     = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
          on_last_d = bus.speed ? FAST_LAST : SLOW_LAST;
          idx_d     = '0;
          timer_d   = '0;
          state_d   = (bus.length == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        color_d = bus.mem_data;
        timer_d = '0;
        state_d = S_ON;
      end
      S_ON: begin
        if (timer_q == on_last_q) begin
          timer_d = '0;
          state_d = S_OFF;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_OFF: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? S_FINISH : S_FETCH;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Abort drops straight to idle, skipping the done pulse.
    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      timer_q   <= '0;
      on_last_q <= '0;
      color_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      timer_q   <= timer_d;
      on_last_q <= on_last_d;
      color_q   <= color_d;
    end
  end

  assign bus.mem_rd     = (state_q == S_FETCH);
  assign bus.mem_addr   = idx_q[ADDR_WIDTH-1:0];
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_FINISH);
  assign bus.led_red    = (state_q == S_ON) && (color_q == DATA_WIDTH'(0));
  assign bus.led_green  = (state_q == S_ON) && (color_q == DATA_WIDTH'(1));
  assign bus.led_blue   = (state_q == S_ON) && (color_q == DATA_WIDTH'(2));
  assign bus.led_yellow = (state_q == S_ON) && (color_q == DATA_WIDTH'(3));

endmodule

// File: tb/tb_led_playback_sequencer.sv
// Directed bench for led_playback_sequencer: a per-cycle vector table plus
// hand-built sequences for full playback, clamping, abort, reset and re-start.
module tb_led_playback_sequencer;
  localparam int AW   = 5;
  localparam int DW   = 2;
  localparam int SLOW = 8;
  localparam int FAST = 4;
  localparam int GAP  = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  led_playback_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  led_playback_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SLOW_ON(SLOW), .FAST_ON(FAST), .GAP(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Sequence memory with one cycle of read latency.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
  end

  // Observed outputs packed as {mem_rd, addr, yellow, blue, green, red, busy, done}.
  logic [11:0] obs;
  assign obs = {bus.mem_rd, bus.mem_addr, bus.led_yellow, bus.led_blue,
                bus.led_green, bus.led_red, bus.busy, bus.done};

  typedef struct {
    string       name;
    logic        rst;
    logic        start;
    logic        abort;
    logic [5:0]  length;
    logic        speed;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [11:0] expOut(logic rd, logic [4:0] addr, logic [3:0] leds,
                                         logic busy, logic done);
    return {rd, addr, leds, busy, done};
  endfunction

  function automatic logic [3:0] ledCode(logic [DW-1:0] c);
    return 4'b0001 << c;
  endfunction

  // Expected outputs k cycles after a start edge for an undisturbed playback.
  function automatic logic [11:0] schedExp(int len, int onT, int k);
    int p = 2 + onT + GAP;
    int i;
    int ph;
    if (k <= p * len) begin
      i  = (k - 1) / p;
      ph = (k - 1) % p;
      return expOut(ph == 0, 5'(i), (ph >= 2 && ph < 2 + onT) ? ledCode(mem[i]) : 4'b0, 1'b1, 1'b0);
    end
    return expOut(1'b0, 5'(len), 4'b0, 1'(k == p * len + 1), 1'(k == p * len + 1));
  endfunction

  function automatic vec_t mk(string name, logic r, logic s, logic a, logic [5:0] len,
                              logic spd, logic [11:0] e);
    vec_t v;
    v.name = name; v.rst = r; v.start = s; v.abort = a;
    v.length = len; v.speed = spd; v.exp = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; bus.start = v.start; bus.abort = v.abort;
    bus.length = v.length; bus.speed = v.speed;
    @(negedge clk);
    checkOutput(v.name, int'(obs), int'(v.exp));
  endtask

  // Starts a playback and checks every cycle; disturb re-pulses start and flips inputs.
  task automatic playAndCheck(input string tag, input int len, input int onT, input bit disturb);
    int p = 2 + onT + GAP;
    bus.length = 6'(len); bus.speed = (onT == FAST); bus.abort = 1'b0; bus.start = 1'b1;
    for (int k = 1; k <= p * len + 2; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (disturb && (k == 4 || k == p + 3)) begin
        bus.start = 1'b1; bus.speed = ~bus.speed; bus.length = 6'd1;
      end
      checkOutput($sformatf("%s_k%0d", tag, k), int'(obs), int'(schedExp(len, onT, k)));
    end
  endtask

  task automatic countRun(input string tag, input int len, input int onT, input int expReads);
    int p = 2 + onT + GAP;
    int reads = 0, dones = 0, doneAt = 0, badAddr = 0, k = 0;
    bus.length = 6'(len); bus.speed = (onT == FAST); bus.abort = 1'b0; bus.start = 1'b1;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      k++;
      if (bus.mem_rd) begin
        if (bus.mem_addr != 5'(reads)) badAddr++;
        reads++;
      end
      if (bus.done) begin dones++; doneAt = k; end
    end while (bus.busy && k < 1000);
    checkOutput({tag, "_reads"}, reads, expReads);
    checkOutput({tag, "_addr_order_errors"}, badAddr, 0);
    checkOutput({tag, "_done_count"}, dones, 1);
    checkOutput({tag, "_done_cycle"}, doneAt, expReads * p + 1);
    checkOutput({tag, "_idle_at_end"}, int'(bus.busy), 0);
  endtask

  initial begin
    int doneSeen;
    for (int i = 0; i < 32; i++) mem[i] = 2'(i);
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;
    rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.length = '0; bus.speed = 1'b0;

    vecs[0]  = mk("reset",          1, 0, 0, 6'd0, 0, expOut(0, 0, 4'b0000, 0, 0));
    vecs[1]  = mk("abort_beats_start", 0, 1, 1, 6'd3, 0, expOut(0, 0, 4'b0000, 0, 0));
    vecs[2]  = mk("len0_finish",    0, 1, 0, 6'd0, 0, expOut(0, 0, 4'b0000, 1, 1));
    vecs[3]  = mk("len0_idle",      0, 0, 0, 6'd0, 0, expOut(0, 0, 4'b0000, 0, 0));
    vecs[4]  = mk("fetch",          0, 1, 0, 6'd1, 1, expOut(1, 0, 4'b0000, 1, 0));
    vecs[5]  = mk("latch",          0, 0, 0, 6'd1, 1, expOut(0, 0, 4'b0000, 1, 0));
    vecs[6]  = mk("on1",            0, 0, 0, 6'd1, 1, expOut(0, 0, 4'b0100, 1, 0));
    vecs[7]  = mk("on2",            0, 0, 0, 6'd1, 1, expOut(0, 0, 4'b0100, 1, 0));
    vecs[8]  = mk("on3",            0, 0, 0, 6'd1, 1, expOut(0, 0, 4'b0100, 1, 0));
    vecs[9]  = mk("on4",            0, 0, 0, 6'd1, 1, expOut(0, 0, 4'b0100, 1, 0));
    vecs[10] = mk("off1",           0, 0, 0, 6'd1, 1, expOut(0, 0, 4'b0000, 1, 0));
    vecs[11] = mk("off2",           0, 0, 0, 6'd1, 1, expOut(0, 0, 4'b0000, 1, 0));
    vecs[12] = mk("finish",         0, 0, 0, 6'd1, 1, expOut(0, 1, 4'b0000, 1, 1));
    vecs[13] = mk("idle_after",     0, 0, 0, 6'd1, 1, expOut(0, 1, 4'b0000, 0, 0));
    vecs[14] = mk("refetch",        0, 1, 0, 6'd1, 0, expOut(1, 0, 4'b0000, 1, 0));
    vecs[15] = mk("latch2",         0, 0, 0, 6'd1, 0, expOut(0, 0, 4'b0000, 1, 0));
    vecs[16] = mk("on_slow",        0, 0, 0, 6'd1, 0, expOut(0, 0, 4'b0100, 1, 0));
    vecs[17] = mk("abort_on",       0, 0, 1, 6'd1, 0, expOut(0, 0, 4'b0000, 0, 0));
    vecs[18] = mk("abort_idle",     0, 0, 0, 6'd1, 0, expOut(0, 0, 4'b0000, 0, 0));

    for (int i = 0; i < 19; i++) applyStimulus(vecs[i]);

    playAndCheck("len3_fast", 3, FAST, 1'b0);

    countRun("len32_slow", 32, SLOW, 32);
    countRun("len40_clamped", 40, FAST, 32);

    // Abort during the second item's ON phase, then replay from address 0.
    bus.length = 6'd3; bus.speed = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("item1_on_red", int'(obs), int'(expOut(0, 1, 4'b0001, 1, 0)));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort_leds_off", int'(obs), int'(expOut(0, 1, 4'b0000, 0, 0)));
    doneSeen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done || bus.busy) doneSeen++;
    end
    checkOutput("abort_no_done", doneSeen, 0);
    playAndCheck("replay", 1, FAST, 1'b0);

    // Reset during item 1's OFF phase; start is ignored while reset is held.
    bus.length = 6'd3; bus.speed = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    checkOutput("item1_off", int'(obs), int'(expOut(0, 1, 4'b0000, 1, 0)));
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid", int'(obs), int'(expOut(0, 0, 4'b0000, 0, 0)));
    @(negedge clk);
    checkOutput("start_in_reset", int'(obs), int'(expOut(0, 0, 4'b0000, 0, 0)));
    rst = 1'b0; bus.length = 6'd1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("start_after_reset", int'(obs), int'(schedExp(1, FAST, 1)));
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post_reset_k%0d", k), int'(obs), int'(schedExp(1, FAST, k)));
    end

    playAndCheck("disturbed", 2, FAST, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_playback_sequencer.md
LED_PLAYBACK_SEQUENCER -- requirements
Module: led_playback_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- ADDR_WIDTH, 5, sequence memory address width.
- DATA_WIDTH, 2, color code width.
- SLOW_ON, 50_000_000, LED-on cycles when speed=0.
- FAST_ON, 12_500_000, LED-on cycles when speed=1.
- GAP, 5_000_000, all-LEDs-off cycles after each item.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to play items 0..length-1.
- abort  in  1  stop playback immediately.
- length  in  ADDR_WIDTH+1  number of items to play.
- speed  in  1  0=slow, 1=fast.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_WIDTH  read address.
- mem_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd.
- led_red, led_green, led_blue, led_yellow  out  1 each  color LEDs.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when playback completes.

Function
REQ-003 Color decode SHALL be: 0=red, 1=green, 2=blue, 3=yellow. At most one LED SHALL be high in any cycle.
REQ-004 States SHALL be IDLE, FETCH, LATCH, ON, OFF, FINISH, encoded as a 3-bit enumerated type.
REQ-005 In IDLE with start=1, the block SHALL capture length, clamped to 2**ADDR_WIDTH, and speed (the on-time limit). It SHALL clear the item index, then go to FETCH, or to FINISH if the captured length is 0.
REQ-006 In FETCH, mem_rd SHALL be 1 for exactly one cycle with mem_addr equal to the item index, and the next state SHALL be LATCH.
REQ-007 In LATCH, the block SHALL register mem_data into the color register, clear the timer, and go to ON.
REQ-008 In ON, exactly the LED for the color register SHALL be lit for exactly the captured on-time cycles. The block SHALL then clear the timer and go to OFF.
REQ-009 In OFF, all LEDs SHALL be low for exactly GAP cycles. The index SHALL then increment. The next state SHALL be FINISH if the incremented index equals the captured length, otherwise FETCH.
REQ-010 In FINISH, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-011 Cycle timing: with start sampled at edge T, mem_rd SHALL be high in cycle T+1 and the LED SHALL turn on at T+3. Per-item period SHALL be 2+ON+GAP cycles.
REQ-012 In non-IDLE states, mem_rd SHALL be 0 outside FETCH, and mem_addr SHALL hold the current index.
REQ-013 Timer width SHALL be sized for max(SLOW_ON,FAST_ON,GAP) and SHALL never wrap within a phase.
REQ-014 The index SHALL be ADDR_WIDTH+1 bits wide, so that length=2**ADDR_WIDTH terminates without address wrap. mem_addr SHALL be the low ADDR_WIDTH bits of the index.
REQ-015 start while busy SHALL be ignored. Changes to length or speed while busy SHALL have no effect on the current playback.
REQ-016 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with LEDs off and mem_rd=0, and SHALL NOT pulse done.
REQ-017 abort and start asserted together in IDLE: abort SHALL win and no playback SHALL start.
REQ-018 busy SHALL be high from the cycle after start is accepted through the FINISH cycle inclusive.

Reset
REQ-019 rst=1 at a clock edge SHALL take precedence over all inputs, including mid-playback, and SHALL force the following:
- state=IDLE.
- index, timer and color register cleared.
- all LEDs=0, mem_rd=0, mem_addr=0, busy=0, done=0.
REQ-020 Once rst is deasserted, the block SHALL accept start on the first following edge.

Verification
All scenarios use SLOW_ON=8, FAST_ON=4, GAP=2, ADDR_WIDTH=5, memory preloaded with items 0..3 = {2,0,3,1}.
REQ-021 length=3, speed=1, start at T:
- mem_rd at T+1, T+9, T+17.
- blue lit T+3..T+6, red T+11..T+14, yellow T+19..T+22.
- done pulse at T+25, busy low at T+26.
REQ-022 length=0, start -> no mem_rd, no LED, done pulses exactly one cycle later, busy high for that one cycle only.
REQ-023 length=32, speed=0 -> 32 reads, addresses 0..31 in order, no address 0 revisit, exactly one done after 32*12 cycles.
REQ-024 abort during the second item's ON phase -> LEDs off next cycle, state IDLE, no done. A new start then replays from address 0.
REQ-025 rst asserted during OFF of item 1 -> all outputs at reset values next cycle. start with rst=1 is ignored. start one cycle after rst deassertion is accepted.
REQ-026 start re-pulsed and speed toggled mid-playback -> timing and item count unchanged from the original capture, single done.
